dag_index_update: RTL and testbench

//  DAG index/modify/length register file with a 2-stage circular-buffer address update pipeline.

---
 rtl/dag_pkg.sv | 33 +++
 rtl/dag_index_update_if.sv | 28 ++
 rtl/dag_circ_wrap.sv | 29 ++
 rtl/dag_index_update.sv | 121 ++++++++++++
 tb/tb_dag_index_update.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dag_pkg.sv
// Shared types and constants for the DAG index/modify/length register file.
package dag_pkg;

    localparam int unsigned DAG_AW = 14;
    localparam int unsigned NREG   = 4;
    localparam int unsigned IDX_W  = 2;

    // Host register-file target, decoded from WR_SEL[3:2]
    typedef enum logic [1:0] {
        SEL_I    = 2'b00,
        SEL_M    = 2'b01,
        SEL_L    = 2'b10,
        SEL_CTRL = 2'b11
    } sel_type_e;

    // Request record captured at stage A
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] i_sel;
        logic [IDX_W-1:0] m_sel;
        logic             pre;
    } req_a_t;

    // Mirror an address end-for-end (bit0 <-> bit13)
    function automatic logic [DAG_AW-1:0] bit_rev(input logic [DAG_AW-1:0] a);
        logic [DAG_AW-1:0] r;
        for (int k = 0; k < int'(DAG_AW); k++) begin
            r[DAG_AW-1-k] = a[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/dag_index_update_if.sv
// Host write, request, length-decoder and address-output bus of the DAG.
interface dag_index_update_if;
    import dag_pkg::*;

    logic              WR_EN;
    logic [3:0]        WR_SEL;
    logic [DAG_AW-1:0] WR_DATA;
    logic              REQ;
    logic [IDX_W-1:0]  I_SEL;
    logic [IDX_W-1:0]  M_SEL;
    logic              PRE;
    logic [DAG_AW-1:0] LD_L;
    logic [DAG_AW-1:0] LD_PB;
    logic [DAG_AW-1:0] ADDR;
    logic              ADDR_VLD;

    // Host + length decoder side
    modport master (
        output WR_EN, WR_SEL, WR_DATA, REQ, I_SEL, M_SEL, PRE, LD_PB,
        input  LD_L, ADDR, ADDR_VLD
    );

    // DAG side
    modport slave (
        input  WR_EN, WR_SEL, WR_DATA, REQ, I_SEL, M_SEL, PRE, LD_PB,
        output LD_L, ADDR, ADDR_VLD
    );
endinterface

// File: rtl/dag_circ_wrap.sv
// Circular-buffer index update: (I, M, L, base mask) -> next I, single correction.
module dag_circ_wrap
    import dag_pkg::*;
(
    input  logic [DAG_AW-1:0] i_val,
    input  logic [DAG_AW-1:0] m_val,
    input  logic [DAG_AW-1:0] l_val,
    input  logic [DAG_AW-1:0] pb_val,
    output logic [DAG_AW-1:0] inext
);
    logic [DAG_AW-1:0] sum_c;
    logic [DAG_AW-1:0] base_c;
    logic [DAG_AW-1:0] top_c;

    // Modulo-2^14 add, then at most one wrap toward the buffer
    always_comb begin
        sum_c  = i_val + m_val;
        base_c = i_val & pb_val;
        top_c  = base_c + l_val;
        inext  = sum_c;
        if (l_val != '0) begin
            if (!m_val[DAG_AW-1]) begin
                if (sum_c >= top_c) inext = sum_c - l_val;
            end else begin
                if (sum_c < base_c) inext = sum_c + l_val;
            end
        end
    end
endmodule

// File: rtl/dag_index_update.sv
// DAG I/M/L register file with a 2-stage circular address pipeline.
// Optional feature macro: BIT_REVERSE_EN (CTRL bit0 reverses addresses for I_SEL==0).
module dag_index_update
    import dag_pkg::*;
(
    input logic               CLK,
    input logic               RST,
    dag_index_update_if.slave bus
);
    logic [DAG_AW-1:0] i_q [NREG];
    logic [DAG_AW-1:0] i_d [NREG];
    logic [DAG_AW-1:0] m_q [NREG];
    logic [DAG_AW-1:0] m_d [NREG];
    logic [DAG_AW-1:0] l_q [NREG];
    logic [DAG_AW-1:0] l_d [NREG];

    req_a_t            a_q, a_d;
    logic [DAG_AW-1:0] a_i_q, a_i_d;
    logic [DAG_AW-1:0] a_m_q, a_m_d;
    logic [DAG_AW-1:0] a_l_q, a_l_d;

    logic [DAG_AW-1:0] addr_q, addr_d;
    logic              addr_vld_q, addr_vld_d;

`ifdef BIT_REVERSE_EN
    logic              ctrl_q, ctrl_d;
`endif

    logic [DAG_AW-1:0] inext_c;
    logic [DAG_AW-1:0] addr_raw_c;
    sel_type_e         wr_type_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic              unused_m_sel_c;

    assign wr_type_c    = sel_type_e'(bus.WR_SEL[3:2]);
    assign wr_idx_c     = bus.WR_SEL[1:0];
    assign bus.LD_L     = a_l_q;
    assign bus.ADDR     = addr_q;
    assign bus.ADDR_VLD = addr_vld_q;

    // M operand is already captured at stage A; the select travels along only as a record field
    assign unused_m_sel_c = ^a_q.m_sel;

    dag_circ_wrap u_wrap (
        .i_val  (a_i_q),
        .m_val  (a_m_q),
        .l_val  (a_l_q),
        .pb_val (bus.LD_PB),
        .inext  (inext_c)
    );

    // Register file: stage-B writeback first, host write overrides on the same edge
    always_comb begin
        i_d = i_q;
        m_d = m_q;
        l_d = l_q;
        if (a_q.vld) i_d[a_q.i_sel] = inext_c;
        if (bus.WR_EN) begin
            case (wr_type_c)
                SEL_I:   i_d[wr_idx_c] = bus.WR_DATA;
                SEL_M:   m_d[wr_idx_c] = bus.WR_DATA;
                SEL_L:   l_d[wr_idx_c] = bus.WR_DATA;
                default: ;
            endcase
        end
    end

    // Stage A capture: operands read now, I forwarded from the writeback on this edge
    always_comb begin
        a_d   = '{vld: bus.REQ, i_sel: bus.I_SEL, m_sel: bus.M_SEL, pre: bus.PRE};
        a_i_d = i_q[bus.I_SEL];
        if (a_q.vld && (a_q.i_sel == bus.I_SEL)) a_i_d = inext_c;
        a_m_d = m_q[bus.M_SEL];
        a_l_d = l_q[bus.I_SEL];
    end

    // Stage B output: pre/post address select and optional bit reverse
    always_comb begin
        addr_raw_c = a_q.pre ? inext_c : a_i_q;
        addr_vld_d = a_q.vld;
        addr_d     = addr_q;
`ifdef BIT_REVERSE_EN
        ctrl_d = ctrl_q;
        if (bus.WR_EN && (wr_type_c == SEL_CTRL)) ctrl_d = bus.WR_DATA[0];
        if (a_q.vld) addr_d = (ctrl_q && (a_q.i_sel == '0)) ? bit_rev(addr_raw_c) : addr_raw_c;
`else
        if (a_q.vld) addr_d = addr_raw_c;
`endif
    end

    // All state, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_q        <= '{default: '0};
            m_q        <= '{default: '0};
            l_q        <= '{default: '0};
            a_q        <= '0;
            a_i_q      <= '0;
            a_m_q      <= '0;
            a_l_q      <= '0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
`ifdef BIT_REVERSE_EN
            ctrl_q     <= 1'b0;
`endif
        end else begin
            i_q        <= i_d;
            m_q        <= m_d;
            l_q        <= l_d;
            a_q        <= a_d;
            a_i_q      <= a_i_d;
            a_m_q      <= a_m_d;
            a_l_q      <= a_l_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
`ifdef BIT_REVERSE_EN
            ctrl_q     <= ctrl_d;
`endif
        end
    end
endmodule

// File: tb/tb_dag_index_update.sv
// Self-checking bench for dag_index_update: transaction-level model plus directed literals.
module tb_dag_index_update;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dag_index_update_if bus ();

    dag_index_update dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [13:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] seen[$];
    logic [13:0] lit[$];
    logic [13:0] mI [4];
    logic [13:0] mM [4];
    logic [13:0] mL [4];
    bit          mctrl;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Length decoder stand-in: base mask aligns I down to the power of two covering L
    function automatic logic [13:0] pb_of(input logic [13:0] l);
        int p = 1;
        if (l == 14'd0) return 14'h3FFF;
        while (p < int'(l)) p = p * 2;
        return 14'(~(p - 1));
    endfunction

    always_comb bus.LD_PB = pb_of(bus.LD_L);

    function automatic logic [13:0] wrap_model(input int i, input int m, input int l, input int pb);
        int s   = (i + m) % 16384;
        int b   = i & pb;
        int top = (b + l) % 16384;
        if (l == 0) return 14'(s);
        if (m < 8192) return (s >= top) ? 14'((s + 16384 - l) % 16384) : 14'(s);
        return (s < b) ? 14'((s + l) % 16384) : 14'(s);
    endfunction

    function automatic logic [13:0] rev_model(input logic [13:0] a);
        logic [13:0] r = '0;
        for (int k = 0; k < 14; k++) if (a[k]) r[13 - k] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of ADDR_VLD/ADDR against the model's due list
    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (RST) begin
                check("vld_in_reset", 14'(bus.ADDR_VLD), 14'd0);
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("addr_vld", 14'(bus.ADDR_VLD), 14'd1);
                if (bus.ADDR_VLD) begin
                    check("addr", bus.ADDR, exp_q[0].addr);
                    seen.push_back(bus.ADDR);
                end
                void'(exp_q.pop_front());
            end else begin
                check("addr_vld_idle", 14'(bus.ADDR_VLD), 14'd0);
                if (bus.ADDR_VLD) seen.push_back(bus.ADDR);
            end
        end
    endtask

    // One cycle of stimulus; the model consumes it as a whole transaction
    task automatic drive(input bit we, input logic [3:0] ws, input logic [13:0] wd,
                         input bit req, input logic [1:0] is, input logic [1:0] ms, input bit pre);
        logic [13:0] nxt;
        logic [13:0] a;
        @(negedge CLK);
        #1;
        bus.WR_EN   = we;
        bus.WR_SEL  = ws;
        bus.WR_DATA = wd;
        bus.REQ     = req;
        bus.I_SEL   = is;
        bus.M_SEL   = ms;
        bus.PRE     = pre;
        nxt = '0;
        a   = '0;
        if (req) begin
            nxt = wrap_model(int'(mI[is]), int'(mM[ms]), int'(mL[is]), int'(pb_of(mL[is])));
            a   = pre ? nxt : mI[is];
        end
        if (we) begin
            case (ws[3:2])
                2'b00: mI[ws[1:0]] = wd;
                2'b01: mM[ws[1:0]] = wd;
                2'b10: mL[ws[1:0]] = wd;
                default: begin
`ifdef BIT_REVERSE_EN
                    mctrl = wd[0];
`endif
                end
            endcase
        end
        if (req) begin
            mI[is] = nxt;
            if (mctrl && is == 2'd0) a = rev_model(a);
            exp_q.push_back('{cyc + 2, a});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'h0, 14'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] ws, input logic [13:0] wd);
        drive(1'b1, ws, wd, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic rq(input logic [1:0] is, input logic [1:0] ms, input bit pre);
        drive(1'b0, 4'h0, 14'h0, 1'b1, is, ms, pre);
    endtask

    task automatic check_seen(input string name);
        check({name, "_count"}, 14'(seen.size()), 14'(lit.size()));
        for (int k = 0; k < lit.size() && k < seen.size(); k++) check(name, seen[k], lit[k]);
        seen.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            mI[k] = '0;
            mM[k] = '0;
            mL[k] = '0;
        end
        mctrl = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        bus.WR_EN   = 1'b0;
        bus.WR_SEL  = 4'h0;
        bus.WR_DATA = 14'h0;
        bus.REQ     = 1'b0;
        bus.I_SEL   = 2'd0;
        bus.M_SEL   = 2'd0;
        bus.PRE     = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (2) @(negedge CLK);
        check("rst_addr", bus.ADDR, 14'h0);
        check("rst_vld", 14'(bus.ADDR_VLD), 14'h0);
        check("rst_ld_l", bus.LD_L, 14'h0);
        #1 RST = 1'b0;

        // Linear addressing
        wr(4'b1000, 14'h0);
        wr(4'b0000, 14'h0010);
        wr(4'b0100, 14'h0003);
        repeat (3) rq(2'd0, 2'd0, 1'b0);
        idle(4);
        lit = '{14'h0010, 14'h0013, 14'h0016};
        check_seen("linear");

        // Upward wrap in a 10-entry buffer at base 0x20
        wr(4'b1001, 14'd10);
        wr(4'b0001, 14'h0025);
        wr(4'b0101, 14'h0004);
        repeat (4) rq(2'd1, 2'd1, 1'b0);
        idle(4);
        lit = '{14'h0025, 14'h0029, 14'h0023, 14'h0027};
        check_seen("wrap_up");

        // Downward wrap with pre-modify
        wr(4'b1010, 14'd8);
        wr(4'b0010, 14'h0041);
        wr(4'b0110, 14'h3FFD);
        rq(2'd2, 2'd2, 1'b1);
        rq(2'd2, 2'd2, 1'b0);
        idle(4);
        lit = '{14'h0046, 14'h0046};
        check_seen("wrap_down");

        // Back-to-back requests on one I register
        wr(4'b0000, 14'h0);
        wr(4'b0100, 14'h1);
        repeat (5) rq(2'd0, 2'd0, 1'b0);
        idle(4);
        lit = '{14'h0, 14'h1, 14'h2, 14'h3, 14'h4};
        check_seen("forward");

        // Host write to I3 on the edge its writeback lands
        wr(4'b1011, 14'h0);
        wr(4'b0111, 14'h1);
        wr(4'b0011, 14'h0005);
        rq(2'd3, 2'd3, 1'b0);
        wr(4'b0011, 14'h0100);
        idle(1);
        rq(2'd3, 2'd3, 1'b0);
        idle(4);
        lit = '{14'h0005, 14'h0100};
        check_seen("collision");

`ifdef BIT_REVERSE_EN
        wr(4'b1100, 14'h1);
        wr(4'b0000, 14'h1);
        rq(2'd0, 2'd0, 1'b0);
        idle(4);
        lit = '{14'h2000};
        check_seen("bitrev");
        wr(4'b1100, 14'h0);
`endif

        // Reset while requests are in flight
        rq(2'd0, 2'd0, 1'b0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        check("midrst_addr", bus.ADDR, 14'h0);
        check("midrst_ld_l", bus.LD_L, 14'h0);
        #1;
        RST     = 1'b0;
        bus.REQ = 1'b0;
        idle(3);
        lit = {};
        check_seen("reset_drop");
        for (int k = 0; k < 4; k++) rq(2'(k), 2'(k), 1'b0);
        idle(4);
        lit = '{14'h0, 14'h0, 14'h0, 14'h0};
        check_seen("reset_regs");

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bit          we;
            logic [3:0]  ws;
            logic [13:0] wd;
            we = ($urandom_range(0, 3) == 0);
            ws = 4'($urandom_range(0, 15));
            case (ws[3:2])
                2'b01:   wd = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 12))
                                                          : 14'(16384 - $urandom_range(1, 12));
                2'b10:   wd = 14'($urandom_range(0, 40));
                default: wd = 14'($urandom_range(0, 16383));
            endcase
            drive(we, ws, wd, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(6);
        check("drain", 14'(exp_q.size()), 14'h0);
        seen.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
